// File: rtl/loteria_pkg.sv
// Shared types and constants for the lottery front-end and FSM.
// The digit type is common to both sides of the ticket interface.
package loteria_pkg;

  localparam int MAX_DIGIT         = 9;
  localparam int DIGITS_PER_TICKET = 5;

  typedef logic [3:0] digit_t;

  typedef enum logic {
    COLLECT,
    READY
  } state_t;

  function automatic logic digit_ok(digit_t d);
    return d <= digit_t'(MAX_DIGIT);
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus counter debouncer for one active-low key.
// Emits a registered one-cycle pulse on each debounced press.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_d <= 1'b1;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= key_n;
      sync2   <= sync1;
      level_d <= level;
      // Only the 1->0 edge of the debounced level is an event.
      press   <= level_d & ~level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/loteria_input_conditioner.sv
// Conditions raw switches/keys into clean insert/finish pulses
// and enforces the digits-then-finish ticket sequence.
module loteria_input_conditioner
  import loteria_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int DIGITS          = DIGITS_PER_TICKET
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_num,
  input  logic       key_insert_n,
  input  logic       key_finish_n,
  output logic [3:0] num,
  output logic       insert,
  output logic       finish,
  output logic       err_digit,
  output logic [2:0] digit_cnt,
  output logic       ready
);

  logic   ins_ev;
  logic   fin_ev;
  digit_t sw_s1;
  digit_t sw_s2;

  state_t     state;
  state_t     state_nx;
  digit_t     num_nx;
  logic [2:0] cnt_nx;
  logic       ins_nx;
  logic       fin_nx;
  logic       err_nx;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_insert (
    .clk  (clk),
    .reset(reset),
    .key_n(key_insert_n),
    .press(ins_ev)
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_deb_finish (
    .clk  (clk),
    .reset(reset),
    .key_n(key_finish_n),
    .press(fin_ev)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw_num;
      sw_s2 <= sw_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= COLLECT;
      num       <= '0;
      digit_cnt <= '0;
      insert    <= 1'b0;
      finish    <= 1'b0;
      err_digit <= 1'b0;
    end else begin
      state     <= state_nx;
      num       <= num_nx;
      digit_cnt <= cnt_nx;
      insert    <= ins_nx;
      finish    <= fin_nx;
      err_digit <= err_nx;
    end
  end

  // Each state only listens to its own legal key.
  always_comb begin
    state_nx = state;
    num_nx   = num;
    cnt_nx   = digit_cnt;
    ins_nx   = 1'b0;
    fin_nx   = 1'b0;
    err_nx   = err_digit;
    unique case (state)
      COLLECT: begin
        if (ins_ev) begin
          if (digit_ok(sw_s2)) begin
            num_nx = sw_s2;
            cnt_nx = digit_cnt + 3'd1;
            ins_nx = 1'b1;
            err_nx = 1'b0;
            if (cnt_nx == 3'(DIGITS)) begin
              state_nx = READY;
            end
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      READY: begin
        if (fin_ev) begin
          fin_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = COLLECT;
        end
      end
      default: ;
    endcase
  end

  assign ready = (state == READY);

endmodule

// File: tb/tb_loteria_input_conditioner.sv
// Bench for loteria_input_conditioner with a windowed debounce model.
// Directed ticket scenarios followed by randomized key/switch traffic.
module tb_loteria_input_conditioner;

  localparam int DEB = 4;
  localparam int DIG = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw_num = 4'd0;
  logic       key_insert_n = 1'b1;
  logic       key_finish_n = 1'b1;
  logic [3:0] num;
  logic       insert;
  logic       finish;
  logic       err_digit;
  logic [2:0] digit_cnt;
  logic       ready;

  int checks = 0;
  int errors = 0;

  loteria_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (3),
    .DIGITS         (DIG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_num      (sw_num),
    .key_insert_n(key_insert_n),
    .key_finish_n(key_finish_n),
    .num         (num),
    .insert      (insert),
    .finish      (finish),
    .err_digit   (err_digit),
    .digit_cnt   (digit_cnt),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  // Reference: a key level flips once DEB consecutive synced
  // samples disagree with it; the ticket follows plain rules.
  bit           md_i1, md_i2, md_f1, md_f2;
  bit [DEB-1:0] mw_i, mw_f;
  bit           ml_i, ml_f;
  bit [1:0]     mp_i, mp_f;
  logic [3:0]   ms1, ms2, m_num;
  int           m_cnt;
  bit           m_err, m_ins, m_fin;

  task automatic model_edge();
    bit ie, fe;
    if (reset) begin
      md_i1 = 1; md_i2 = 1; md_f1 = 1; md_f2 = 1;
      mw_i = '1; mw_f = '1; ml_i = 1; ml_f = 1;
      mp_i = 0; mp_f = 0; ms1 = 0; ms2 = 0;
      m_num = 0; m_cnt = 0; m_err = 0;
      m_ins = 0; m_fin = 0;
    end else begin
      ie = mp_i[1];
      fe = mp_f[1];
      m_ins = 0;
      m_fin = 0;
      if (m_cnt < DIG) begin
        if (ie) begin
          if (ms2 <= 9) begin
            m_num = ms2; m_cnt++; m_err = 0; m_ins = 1;
          end else begin
            m_err = 1;
          end
        end
      end else if (fe) begin
        m_fin = 1; m_cnt = 0;
      end
      mp_i = {mp_i[0], 1'b0};
      mp_f = {mp_f[0], 1'b0};
      mw_i = {mw_i[DEB-2:0], md_i2};
      mw_f = {mw_f[DEB-2:0], md_f2};
      if (mw_i == {DEB{~ml_i}}) begin
        mp_i[0] = ml_i; ml_i = ~ml_i;
      end
      if (mw_f == {DEB{~ml_f}}) begin
        mp_f[0] = ml_f; ml_f = ~ml_f;
      end
      md_i2 = md_i1; md_i1 = key_insert_n;
      md_f2 = md_f1; md_f1 = key_finish_n;
      ms2 = ms1; ms1 = sw_num;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Hold one key low, release it, and report what came out.
  task automatic press(input bit fk, input int hold,
                       output int ni, output int nf,
                       output int first);
    ni = 0; nf = 0; first = -1;
    for (int i = 0; i < hold + 12; i++) begin
      if (fk) key_finish_n = (i >= hold);
      else    key_insert_n = (i >= hold);
      step();
      if ((insert || finish) && first < 0) first = i;
      ni += int'(insert);
      nf += int'(finish);
    end
  endtask

  task automatic set_sw(input logic [3:0] v);
    sw_num = v;
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) step();
    checks++;
    if ({num, insert, finish, err_digit, digit_cnt, ready} !== 11'd0) begin
      errors++;
      $display("FAIL reset_vals got %h want 0",
               {num, insert, finish, err_digit, digit_cnt, ready});
    end
    reset = 0;
    step();
  endtask

  task automatic test_latency();
    int ni, nf, first;
    set_sw(4'd5);
    press(0, 20, ni, nf, first);
    checks++;
    if (first !== 7) begin
      errors++; $display("FAIL latency got %0d want 7", first);
    end
    checks++;
    if (ni !== 1 || nf !== 0) begin
      errors++; $display("FAIL one_pulse got ins=%0d fin=%0d want 1/0", ni, nf);
    end
    checks++;
    if (num !== 4'd5 || digit_cnt !== 3'd1 || err_digit !== 1'b0) begin
      errors++;
      $display("FAIL first_digit got num=%0d cnt=%0d err=%b want 5/1/0",
               num, digit_cnt, err_digit);
    end
  endtask

  task automatic test_bounce();
    int ni, nf, first, nb;
    logic [3:0] d;
    d = 4'($urandom_range(9));
    set_sw(d);
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      key_insert_n = ((i / 2) % 2) != 0;
      step();
      nb += int'(insert);
    end
    press(0, 20, ni, nf, first);
    checks++;
    if (nb !== 0) begin
      errors++; $display("FAIL bounce_quiet got %0d pulses want 0", nb);
    end
    checks++;
    if (ni !== 1 || first !== 7) begin
      errors++;
      $display("FAIL bounce_press got n=%0d at %0d want 1 at 7", ni, first);
    end
    checks++;
    if (num !== d || digit_cnt !== 3'd2) begin
      errors++;
      $display("FAIL bounce_state got num=%0d cnt=%0d want %0d/2",
               num, digit_cnt, d);
    end
  endtask

  task automatic test_bad_digit();
    int ni, nf, first;
    set_sw(4'd12);
    press(0, 10, ni, nf, first);
    checks++;
    if (ni !== 0 || err_digit !== 1'b1 || digit_cnt !== 3'd2) begin
      errors++;
      $display("FAIL bad_digit got n=%0d err=%b cnt=%0d want 0/1/2",
               ni, err_digit, digit_cnt);
    end
    set_sw(4'd0);
    press(0, 10, ni, nf, first);
    checks++;
    if (ni !== 1 || num !== 4'd0 || err_digit !== 1'b0
        || digit_cnt !== 3'd3) begin
      errors++;
      $display("FAIL zero_digit got n=%0d num=%0d err=%b cnt=%0d want 1/0/0/3",
               ni, num, err_digit, digit_cnt);
    end
  endtask

  task automatic test_ticket();
    int ni, nf, first, nok;
    logic [3:0] seq [5];
    seq = '{4'd5, 4'd0, 4'd9, 4'd6, 4'd7};
    reset = 1; repeat (2) step(); reset = 0;
    nok = 0;
    for (int k = 0; k < 5; k++) begin
      set_sw(seq[k]);
      press(0, 8 + int'($urandom_range(10)), ni, nf, first);
      if (ni == 1 && num == seq[k]) nok++;
    end
    checks++;
    if (nok !== 5) begin
      errors++; $display("FAIL ticket_digits got %0d good want 5", nok);
    end
    checks++;
    if (digit_cnt !== 3'd5 || ready !== 1'b1 || num !== 4'd7) begin
      errors++;
      $display("FAIL ticket_full got cnt=%0d rdy=%b num=%0d want 5/1/7",
               digit_cnt, ready, num);
    end
    set_sw(4'($urandom_range(9)));
    press(0, 10, ni, nf, first);
    checks++;
    if (ni !== 0 || digit_cnt !== 3'd5 || err_digit !== 1'b0) begin
      errors++;
      $display("FAIL sixth_insert got n=%0d cnt=%0d err=%b want 0/5/0",
               ni, digit_cnt, err_digit);
    end
    press(1, 10, ni, nf, first);
    checks++;
    if (nf !== 1 || ni !== 0 || first !== 7) begin
      errors++;
      $display("FAIL finish_pulse got fin=%0d ins=%0d at %0d want 1/0 at 7",
               nf, ni, first);
    end
    checks++;
    if (digit_cnt !== 3'd0 || ready !== 1'b0 || num !== 4'd7) begin
      errors++;
      $display("FAIL after_finish got cnt=%0d rdy=%b num=%0d want 0/0/7",
               digit_cnt, ready, num);
    end
  endtask

  task automatic test_collect_finish();
    int ni, nf, first;
    for (int k = 0; k < 2; k++) begin
      set_sw(4'($urandom_range(9)));
      press(0, 10, ni, nf, first);
    end
    press(1, 10, ni, nf, first);
    checks++;
    if (nf !== 0 || digit_cnt !== 3'd2 || ready !== 1'b0) begin
      errors++;
      $display("FAIL early_finish got fin=%0d cnt=%0d rdy=%b want 0/2/0",
               nf, digit_cnt, ready);
    end
    ni = 0; nf = 0;
    for (int i = 0; i < 32; i++) begin
      key_insert_n = (i >= 20);
      key_finish_n = (i < 1) || (i >= 21);
      step();
      ni += int'(insert);
      nf += int'(finish);
    end
    checks++;
    if (ni !== 1 || nf !== 0 || digit_cnt !== 3'd3) begin
      errors++;
      $display("FAIL both_keys got ins=%0d fin=%0d cnt=%0d want 1/0/3",
               ni, nf, digit_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int early, at7, late;
    logic [3:0] d;
    reset = 1; repeat (2) step(); reset = 0;
    d = 4'($urandom_range(9));
    set_sw(d);
    early = 0;
    key_insert_n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      early += int'(insert);
    end
    reset = 1;
    repeat (2) step();
    checks++;
    if ({num, insert, finish, err_digit, digit_cnt, ready} !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset got %h want 0",
               {num, insert, finish, err_digit, digit_cnt, ready});
    end
    reset = 0;
    at7 = 0; late = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (i == 7) at7 = int'(insert);
      else        late += int'(insert);
    end
    key_insert_n = 1;
    repeat (10) step();
    checks++;
    if (early !== 0 || at7 !== 1 || late !== 0) begin
      errors++;
      $display("FAIL held_reset got early=%0d at7=%0d other=%0d want 0/1/0",
               early, at7, late);
    end
    checks++;
    if (num !== d || digit_cnt !== 3'd1) begin
      errors++;
      $display("FAIL held_state got num=%0d cnt=%0d want %0d/1",
               num, digit_cnt, d);
    end
  endtask

  task automatic test_random();
    int run_i, run_f, bad, both;
    logic [10:0] got, want;
    reset = 1; repeat (2) step(); reset = 0;
    run_i = 0; run_f = 0; bad = 0; both = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_i == 0) begin
        key_insert_n = ~key_insert_n;
        run_i = int'($urandom_range(1, 14));
      end
      if (run_f == 0) begin
        key_finish_n = ~key_finish_n;
        run_f = int'($urandom_range(1, 14));
      end
      run_i--; run_f--;
      if ($urandom_range(7) == 0) sw_num = 4'($urandom_range(15));
      reset = ($urandom_range(400) == 0);
      step();
      got  = {num, insert, finish, err_digit, digit_cnt, ready};
      want = {m_num, m_ins, m_fin, m_err, 3'(m_cnt), m_cnt == DIG};
      checks++;
      if (got !== want) begin
        errors++;
        if (bad < 10)
          $display("FAIL rand_cycle %0d got %h want %h", i, got, want);
        bad++;
      end
      checks++;
      if ((insert && finish) || digit_cnt > 3'(DIG)) begin
        errors++;
        if (both < 10)
          $display("FAIL rand_excl %0d got ins=%b fin=%b cnt=%0d",
                   i, insert, finish, digit_cnt);
        both++;
      end
    end
    reset = 0;
    key_insert_n = 1;
    key_finish_n = 1;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_bounce();
    test_bad_digit();
    test_ticket();
    test_collect_finish();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/loteria_input_conditioner.md
Name: loteria_input_conditioner

Overview:
Front-end stage that sits directly upstream of the lottery FSM on the board. It synchronizes the raw digit switches and debounces the two active-low pushbuttons. It validates the BCD digit and enforces the 5-digits-then-finish ticket sequence. Downstream it delivers clean single-cycle insert/finish pulses with a held, valid digit.

Parameters:
DEBOUNCE_CYCLES, 500000, stable-level cycles required to accept a key change (10 ms at 50 MHz); use 4 in simulation
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
DIGITS, 5, digits per ticket

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sw_num  in  4  raw digit switches, asynchronous
key_insert_n  in  1  raw insert pushbutton, active-low, asynchronous, bouncy
key_finish_n  in  1  raw finish pushbutton, active-low, asynchronous, bouncy
num  out  4  accepted digit, registered, held until next accepted insert
insert  out  1  one-cycle pulse per accepted digit
finish  out  1  one-cycle pulse per accepted finish
err_digit  out  1  level: last insert attempt carried a digit > 9
digit_cnt  out  3  digits accepted in current ticket, 0..DIGITS
ready  out  1  high when digit_cnt == DIGITS (finish allowed)

Behaviour:
- Reset is the already-decided signal: reset, synchronous, active-high; clock clk. All logic is on the clk rising edge.
- Reset values: num=0, insert=0, finish=0, err_digit=0, digit_cnt=0, ready=0. Key synchronizers and debounced levels reset to released (1). Switch synchronizers reset to 0. Debounce counters reset to 0. The FSM resets to COLLECT.
- Synchronization: two-flop synchronizer on each key and on each sw_num bit. No logic reads the raw inputs.
- Debounce (per key):
  - Debounced level L and counter C.
  - When synced input != L: C increments.
  - When synced input == L: C clears.
  - When C reaches DEBOUNCE_CYCLES-1 and the input still differs: L takes the input and C clears.
  - A press event is L going 1->0 and lasts one cycle. Release events are ignored.
- Latency: for a clean press held steady, the insert/finish pulse is high exactly DEBOUNCE_CYCLES+3 clocks after the first clk edge that samples the low level.
- Any glitch shorter than DEBOUNCE_CYCLES cycles produces no event.
- FSM has two states:
  - COLLECT (digit_cnt < DIGITS):
    - insert event with synced sw_num <= 9: num <= sw_num, insert pulse, digit_cnt++, err_digit <= 0. If the new count equals DIGITS, go to READY.
    - insert event with sw_num > 9: no pulse, num and digit_cnt unchanged, err_digit <= 1.
    - finish event: ignored, no pulse.
  - READY (digit_cnt == DIGITS, ready=1):
    - insert event: ignored (no pulse, err_digit unchanged).
    - finish event: finish pulse, digit_cnt <= 0, go to COLLECT. num is held.
- Simultaneous insert and finish events in the same cycle: only the event legal in the current state acts. At most one output pulse per cycle; insert and finish are never both high.
- Key held indefinitely produces exactly one event. A new event requires a debounced release followed by a debounced press.
- Reset mid-debounce or mid-ticket:
  - The partial count is discarded and no pulse is emitted.
  - A key still held after reset deasserts is accepted as a fresh press after the normal debounce latency.
- digit_cnt never exceeds DIGITS and never wraps.

Decomposition:
- Shared package loteria_pkg holds:
  - MAX_DIGIT=9
  - DIGITS_PER_TICKET=5
  - FSM state enum {COLLECT, READY}
  - the 4-bit digit type, shared with the lottery FSM
- One natural sub-module, key_debouncer (parameters DEBOUNCE_CYCLES, CNT_W): 2-flop sync, counter, debounced level, press-event pulse. It is instantiated twice.
- Switch synchronization and the FSM live in the top.

Test Plan:
(All scenarios run with DEBOUNCE_CYCLES=4.)
1. Reset; sw_num=5; key_insert_n low held 20 cycles -> single insert pulse 7 clocks after first sampling edge, num=5, digit_cnt=1, err_digit=0.
2. key_insert_n toggled every 2 cycles for 12 cycles, then held low -> exactly one insert pulse, after the stable period; none during bouncing.
3. sw_num=12, press insert -> no pulse, err_digit=1, digit_cnt unchanged. Then sw_num=0, press -> insert pulse, num=0, err_digit=0.
4. Five valid inserts (5,0,9,6,7) -> digit_cnt=5, ready=1, num=7. Sixth insert press -> no pulse. Finish press -> one finish pulse, digit_cnt=0, ready=0.
5. digit_cnt=2, press finish -> no finish pulse, state remains COLLECT. Press insert and finish within the same debounce window -> only the insert pulse.
6. Assert reset 2 cycles before an expected insert pulse -> no pulse, all outputs at reset values. Key held across reset -> one insert pulse DEBOUNCE_CYCLES+3 clocks after reset deasserts.
